// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the Laplacian convolution sequencer.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int DEF_IMG_W = 28;
    localparam int DEF_IMG_H = 28;

    // Bits needed to hold 0..value-1, never narrower than one bit.
    function automatic int width_of(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    function automatic int win_count(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/conv_valid_pipe.sv
// Valid-token shift register; taps[i] is the input delayed by i+1 cycles.
module conv_valid_pipe #(
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             din,
    output logic [DEPTH-1:0] taps
);

    always_ff @(posedge clk) begin
        if (clear) begin
            taps <= '0;
        end else begin
            taps <= {taps[DEPTH-2:0], din};
        end
    end

endmodule

// File: rtl/laplacian_conv_sequencer.sv
// Raster-order window sequencer for the 3x3 Laplacian datapath: issues window
// addresses, steps the adder-stage enables and emits result write addresses.
module laplacian_conv_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W       = DEF_IMG_W,
    parameter int IMG_H       = DEF_IMG_H,
    parameter int RD_LAT      = 1,
    parameter int PIPE_STAGES = 4,
    localparam int ROW_W = width_of(IMG_H),
    localparam int COL_W = width_of(IMG_W),
    localparam int RD_W  = width_of(IMG_W * IMG_H),
    localparam int WR_W  = width_of(win_count(IMG_W, IMG_H))
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    output logic [ROW_W-1:0]       win_row,
    output logic [COL_W-1:0]       win_col,
    output logic [RD_W-1:0]        rd_addr,
    output logic                   win_valid,
    output logic [PIPE_STAGES-1:0] stage_en,
    output logic [WR_W-1:0]        wr_addr,
    output logic                   wr_en,
    output logic                   busy,
    output logic                   done
);

    localparam int N     = win_count(IMG_W, IMG_H);
    localparam int DEPTH = RD_LAT + PIPE_STAGES;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 2);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 2);
    localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(N - 1);
    localparam logic [RD_W-1:0]  IMG_W_RD = RD_W'(IMG_W);

    state_t           state;
    logic [DEPTH-1:0] taps;
    logic [ROW_W-1:0] row_nxt;
    logic [COL_W-1:0] col_nxt;
    logic             last_win;

    assign last_win = (win_row == ROW_LAST) && (win_col == COL_LAST);

    always_comb begin
        row_nxt = win_row;
        col_nxt = win_col + COL_W'(1);
        if (win_col == COL_LAST) begin
            row_nxt = win_row + ROW_W'(1);
            col_nxt = COL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state     <= IDLE;
            win_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            if (reset) begin
                win_row <= '0;
                win_col <= '0;
                rd_addr <= '0;
                wr_addr <= '0;
            end
        end else begin
            done <= 1'b0;
            if (wr_en) begin
                wr_addr <= wr_addr + WR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        win_valid <= 1'b1;
                        win_row   <= ROW_W'(1);
                        win_col   <= COL_W'(1);
                        rd_addr   <= IMG_W_RD + RD_W'(1);
                        wr_addr   <= '0;
                    end
                end
                RUN: begin
                    if (last_win) begin
                        state     <= DRAIN;
                        win_valid <= 1'b0;
                    end else begin
                        win_row <= row_nxt;
                        win_col <= col_nxt;
                        rd_addr <= RD_W'(row_nxt) * IMG_W_RD + RD_W'(col_nxt);
                    end
                end
                // The last result is the one whose index is N-1; every earlier
                // token has already left the pipe by then.
                DRAIN: begin
                    if (wr_en && (wr_addr == WR_LAST)) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    conv_valid_pipe #(
        .DEPTH(DEPTH)
    ) u_valid_pipe (
        .clk  (clk),
        .clear(reset | abort),
        .din  (win_valid),
        .taps (taps)
    );

    assign stage_en = taps[DEPTH-2:RD_LAT-1];
    assign wr_en    = taps[DEPTH-1];

endmodule
